posit_adder_arbiter: RTL and testbench

//  Shares one fully pipelined posit adder (no stall, one op/cycle, fixed latency LAT start->done) among NREQ requesters.

---
 rtl/posit_adder_arbiter.sv | 153 +++++++++++++++
 tb/tb_posit_adder_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/posit_adder_arbiter.sv
// Round-robin arbiter sharing one pipelined posit adder among NREQ requesters.
// A tag pipe follows each op through the adder; credits reserve a response FIFO slot per issued op.
module posit_adder_arbiter #(
    parameter int N          = 32,
    parameter int NREQ       = 4,
    parameter int LAT        = 4,
    parameter int FIFO_DEPTH = 8,
    localparam int IDW       = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*N-1:0]    req_in1,
    input  logic [NREQ*N-1:0]    req_in2,
    output logic                 add_start,
    output logic [N-1:0]         add_in1,
    output logic [N-1:0]         add_in2,
    input  logic                 add_done,
    input  logic [N-1:0]         add_result,
    input  logic                 add_inf,
    input  logic                 add_zero,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [IDW-1:0]       resp_id,
    output logic [N-1:0]         resp_result,
    output logic                 resp_inf,
    output logic                 resp_zero,
    output logic                 err
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int DW = $clog2(LAT + 2);
    localparam int FW = IDW + N + 2;

    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] gnt;
    logic           gnt_vld;
    logic           can_issue;
    logic           accept;
    logic           pop;
    logic           push;
    logic [CW-1:0]  outstanding;
    logic [DW-1:0]  drain;
    logic [IDW-1:0] start_id;
    logic [LAT-1:0] tag_vld;
    logic [IDW-1:0] tag_id [LAT];

    logic [FW-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  fifo_count;

    assign can_issue = (outstanding < CW'(FIFO_DEPTH)) && (drain == '0);
    assign accept    = gnt_vld;
    assign pop       = resp_valid && resp_ready;

    // Search starts at rr_ptr and wraps, so the last winner has lowest priority next time.
    always_comb begin : grant_logic
        int idx;
        idx       = 0;
        gnt       = '0;
        gnt_vld   = 1'b0;
        req_ready = '0;
        if (can_issue) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = int'(rr_ptr) + k;
                if (idx >= NREQ) idx = idx - NREQ;
                if (!gnt_vld && req_valid[idx]) begin
                    gnt_vld = 1'b1;
                    gnt     = IDW'(idx);
                end
            end
        end
        if (gnt_vld) req_ready[gnt] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            add_start   <= 1'b0;
            add_in1     <= '0;
            add_in2     <= '0;
            start_id    <= '0;
            rr_ptr      <= '0;
            outstanding <= '0;
        end else begin
            add_start <= accept;
            if (accept) begin
                add_in1  <= req_in1[int'(gnt)*N +: N];
                add_in2  <= req_in2[int'(gnt)*N +: N];
                start_id <= gnt;
                rr_ptr   <= (int'(gnt) == NREQ - 1) ? '0 : gnt + 1'b1;
            end
            if (accept && !pop)
                outstanding <= outstanding + 1'b1;
            else if (!accept && pop)
                outstanding <= outstanding - 1'b1;
        end
    end

    // The add_start register acts as the head of the tag pipe; its last entry lines up with add_done.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_vld <= '0;
            for (int s = 0; s < LAT; s++) tag_id[s] <= '0;
        end else begin
            tag_vld[0] <= add_start;
            tag_id[0]  <= start_id;
            for (int s = 1; s < LAT; s++) begin
                tag_vld[s] <= tag_vld[s-1];
                tag_id[s]  <= tag_id[s-1];
            end
        end
    end

    // After reset the adder may still emit pulses for ops it was fed earlier; drain masks them.
    always_ff @(posedge clk) begin
        if (reset) begin
            drain <= DW'(LAT + 1);
            err   <= 1'b0;
        end else begin
            if (drain != '0) drain <= drain - 1'b1;
            if (drain == '0 && add_done != tag_vld[LAT-1]) err <= 1'b1;
        end
    end

    assign push = (drain == '0) && add_done && tag_vld[LAT-1];

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {tag_id[LAT-1], add_result, add_inf, add_zero};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign resp_valid = (fifo_count != '0);
    assign {resp_id, resp_result, resp_inf, resp_zero} = fifo_mem[rd_ptr];

endmodule

// File: tb/tb_posit_adder_arbiter.sv
// Directed bench for posit_adder_arbiter: a stand-in adder pipeline plus an in-order scoreboard.
module tb_posit_adder_arbiter;

    localparam int N          = 32;
    localparam int NREQ       = 4;
    localparam int LAT        = 4;
    localparam int FIFO_DEPTH = 8;
    localparam int IDW        = $clog2(NREQ);
    localparam logic [N-1:0] NAR = 32'h8000_0000;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_in1;
    logic [NREQ*N-1:0] req_in2;
    logic              add_start;
    logic [N-1:0]      add_in1;
    logic [N-1:0]      add_in2;
    logic              add_done;
    logic [N-1:0]      add_result;
    logic              add_inf;
    logic              add_zero;
    logic              resp_valid;
    logic              resp_ready;
    logic [IDW-1:0]    resp_id;
    logic [N-1:0]      resp_result;
    logic              resp_inf;
    logic              resp_zero;
    logic              err;
    logic              inject_done;

    int compare_count = 0;
    int fail_count    = 0;

    logic [IDW+N+1:0] exp_q [$];
    logic [LAT-1:0]   mdl_vld = '0;
    logic [N+1:0]     mdl_pipe [LAT];

    posit_adder_arbiter #(
        .N(N), .NREQ(NREQ), .LAT(LAT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_in1(req_in1), .req_in2(req_in2),
        .add_start(add_start), .add_in1(add_in1), .add_in2(add_in2),
        .add_done(add_done), .add_result(add_result),
        .add_inf(add_inf), .add_zero(add_zero),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_result(resp_result),
        .resp_inf(resp_inf), .resp_zero(resp_zero),
        .err(err)
    );

    always #5 clk = ~clk;

    // Stand-in adder returns {inf, zero, result}; exact for the directed posit cases.
    function automatic logic [N+1:0] model_add(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] s;
        if (a == NAR || b == NAR) return {1'b1, 1'b0, NAR};
        if (a == 32'h4000_0000 && b == 32'h4000_0000) return {2'b00, 32'h4800_0000};
        s = a + b;
        return {1'b0, (s == '0), s};
    endfunction

    always @(posedge clk) begin
        mdl_vld[0]  <= add_start;
        mdl_pipe[0] <= model_add(add_in1, add_in2);
        for (int s = 1; s < LAT; s++) begin
            mdl_vld[s]  <= mdl_vld[s-1];
            mdl_pipe[s] <= mdl_pipe[s-1];
        end
    end

    assign add_done   = mdl_vld[LAT-1] | inject_done;
    assign add_result = mdl_pipe[LAT-1][N-1:0];
    assign add_zero   = mdl_pipe[LAT-1][N];
    assign add_inf    = mdl_pipe[LAT-1][N+1];

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compare_count++;
        if (got !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] valid, input int idx,
                                 input logic [N-1:0] in1, input logic [N-1:0] in2);
        req_in1[idx*N +: N] = in1;
        req_in2[idx*N +: N] = in2;
        req_valid           = valid;
    endtask

    task automatic wait_resp(input int maxc);
        int n = 0;
        while (!resp_valid && n < maxc) begin
            tick();
            n++;
        end
        checkOutput("wait_resp_valid", resp_valid, 1);
    endtask

    task automatic wait_sb_empty(input string tag, input int maxc);
        int n = 0;
        while (exp_q.size() != 0 && n < maxc) begin
            tick();
            n++;
        end
        checkOutput(tag, exp_q.size(), 0);
    endtask

    // Scoreboard: record accepts and check every pop against the in-order expectation.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
        end else begin
            for (int i = 0; i < NREQ; i++)
                if (req_valid[i] && req_ready[i])
                    exp_q.push_back({IDW'(i), model_add(req_in1[i*N +: N], req_in2[i*N +: N])});
            if (resp_valid && resp_ready) begin
                if (exp_q.size() == 0)
                    checkOutput("resp_unexpected", 1, 0);
                else
                    checkOutput("resp_head", {resp_id, resp_inf, resp_zero, resp_result},
                                exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [NREQ-1:0] exp_gnt;
        int accepts;

        reset       = 1'b1;
        req_valid   = '1;
        req_in1     = '0;
        req_in2     = '0;
        resp_ready  = 1'b0;
        inject_done = 1'b0;
        repeat (2) tick();
        checkOutput("rst_add_start", add_start, 0);
        checkOutput("rst_add_in1", add_in1, 0);
        checkOutput("rst_add_in2", add_in2, 0);
        checkOutput("rst_resp_valid", resp_valid, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_req_ready", req_ready, 0);
        reset     = 1'b0;
        req_valid = '0;
        repeat (LAT + 1) tick();

        $display("[TB] round-robin with all requesters active");
        for (int i = 0; i < NREQ; i++)
            applyStimulus('1, i, 32'h0100_0000 * (i + 1), 32'h0000_0010 * (i + 1));
        resp_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            exp_gnt = NREQ'(1) << (c % NREQ);
            #1 checkOutput("rr_grant", req_ready, exp_gnt);
            tick();
        end
        req_valid = '0;
        wait_sb_empty("rr_drain", 40);

        $display("[TB] single op latency");
        resp_ready = 1'b0;
        applyStimulus(4'b0100, 2, 32'h4000_0000, 32'h4000_0000);
        #1 checkOutput("single_ready", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        checkOutput("single_add_start", add_start, 1);
        checkOutput("single_add_in1", add_in1, 32'h4000_0000);
        checkOutput("single_add_in2", add_in2, 32'h4000_0000);
        repeat (4) tick();
        checkOutput("single_not_early", resp_valid, 0);
        tick();
        checkOutput("single_resp_valid", resp_valid, 1);
        checkOutput("single_resp_id", resp_id, 2);
        checkOutput("single_resp_result", resp_result, 32'h4800_0000);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        checkOutput("single_popped", resp_valid, 0);

        $display("[TB] zero and inf flags");
        applyStimulus(4'b0010, 1, 32'h4000_0000, 32'hC000_0000);
        tick();
        applyStimulus(4'b1000, 3, NAR, 32'h3F00_0000);
        tick();
        req_valid = '0;
        wait_resp(20);
        checkOutput("zero_flag", resp_zero, 1);
        checkOutput("zero_inf_flag", resp_inf, 0);
        checkOutput("zero_id", resp_id, 1);
        checkOutput("zero_result", resp_result, 0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        checkOutput("inf_valid", resp_valid, 1);
        checkOutput("inf_flag", resp_inf, 1);
        checkOutput("inf_id", resp_id, 3);
        checkOutput("inf_result", resp_result, NAR);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        checkOutput("flags_empty", resp_valid, 0);

        $display("[TB] credit limit with stalled consumer");
        for (int i = 0; i < NREQ; i++)
            applyStimulus('1, i, 32'h0200_0000 + 32'(i), 32'h0000_0100 * (i + 1));
        accepts = 0;
        for (int c = 0; c < 20; c++) begin
            #1 if (|req_ready) accepts++;
            tick();
        end
        checkOutput("credit_accepts", accepts, FIFO_DEPTH);
        #1 checkOutput("credit_blocked", req_ready, 0);
        checkOutput("credit_head_valid", resp_valid, 1);
        resp_ready = 1'b1;
        #1 checkOutput("credit_no_same_cycle", req_ready, 0);
        tick();
        resp_ready = 1'b0;
        #1 checkOutput("credit_reuse_onehot", $onehot(req_ready), 1);
        tick();
        #1 checkOutput("credit_full_again", req_ready, 0);
        req_valid  = '0;
        resp_ready = 1'b1;
        wait_sb_empty("credit_drain", 60);
        checkOutput("credit_err", err, 0);

        $display("[TB] reset with ops in flight");
        req_valid = '1;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        checkOutput("midrst_resp_valid", resp_valid, 0);
        checkOutput("midrst_add_start", add_start, 0);
        tick();
        reset = 1'b0;
        for (int c = 0; c < LAT + 1; c++) begin
            #1 checkOutput("drain_ready", req_ready, 0);
            checkOutput("drain_resp_valid", resp_valid, 0);
            checkOutput("drain_err", err, 0);
            tick();
        end
        resp_ready = 1'b0;
        #1 checkOutput("drain_first_grant", req_ready, 4'b0001);
        tick();
        req_valid = '0;

        $display("[TB] spurious add_done");
        wait_resp(20);
        repeat (LAT + 2) tick();
        inject_done = 1'b1;
        tick();
        inject_done = 1'b0;
        checkOutput("spur_err", err, 1);
        repeat (3) tick();
        checkOutput("spur_err_sticky", err, 1);
        checkOutput("spur_head_valid", resp_valid, 1);
        checkOutput("spur_head_id", resp_id, 0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        checkOutput("spur_no_push", resp_valid, 0);
        checkOutput("spur_sb_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
        $finish;
    end

endmodule
